// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: jump opcodes, instruction field positions,
// the fetch FSM state encoding and the default reset PC.
package instr_fetch_unit_pkg;

    // Default fetch address after reset (word aligned)
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Opcodes of the absolute jumps resolved inside the fetch stage
    localparam logic [5:0] OPC_J_DEFAULT   = 6'b000010;
    localparam logic [5:0] OPC_JAL_DEFAULT = 6'b000011;

    // Instruction field positions, shared with the decoder
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int ADDR_MSB = 25;
    localparam int ADDR_LSB = 0;

    // Fetch FSM: request outstanding / instruction held for downstream
    typedef enum logic {
        S_REQ = 1'b0,
        S_OUT = 1'b1
    } fetch_state_e;

    // Instruction memory is word addressed; low byte-offset bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_next_pc.sv
// Sequential-fetch / jump-target computation for the instruction just handed
// downstream. Purely combinational.
module fetch_next_pc
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [5:0] OPC_J   = OPC_J_DEFAULT,
    parameter logic [5:0] OPC_JAL = OPC_JAL_DEFAULT
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic        is_jump;

    // J/JAL take the upper nibble of pc+4 and the 26-bit word index; all else falls through
    always_comb begin
        pc_plus4 = pc + 32'd4;
        opcode   = instr[OPC_MSB:OPC_LSB];
        is_jump  = (opcode == OPC_J) || (opcode == OPC_JAL);
        if (is_jump) begin
            next_pc = {pc_plus4[31:28], instr[ADDR_MSB:ADDR_LSB], 2'b00};
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one instruction-memory read at a
// time, and holds each fetched word for the datapath under valid/ready.
// A redirect that arrives while a read is in flight cannot change the bus
// address, so the read is allowed to finish and its data is squashed.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [5:0]  OPC_J    = OPC_J_DEFAULT,
    parameter logic [5:0]  OPC_JAL  = OPC_JAL_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    fetch_state_e state_reg;
    logic [31:0]  pc_reg;          // next fetch PC (may run ahead of addr_reg after a squash)
    logic [31:0]  addr_reg;        // address of the read currently on the bus
    logic         squash_reg;      // in-flight read belongs to a redirected-away path
    logic [31:0]  instr_reg;
    logic [31:0]  instr_pc_reg;
    logic         instr_valid_reg;

    logic [31:0]  next_pc;
    logic [31:0]  redirect_aligned;

    assign redirect_aligned = word_align(i_redirect_pc);

    fetch_next_pc #(
        .OPC_J   (OPC_J),
        .OPC_JAL (OPC_JAL)
    ) u_next_pc (
        .instr   (instr_reg),
        .pc      (instr_pc_reg),
        .next_pc (next_pc)
    );

    // Request is a decode of the FSM state; it is held off while reset is applied
    // so the memory never sees a request during the reset cycle.
    assign o_imem_req    = (state_reg == S_REQ) && !i_rst;
    assign o_imem_addr   = addr_reg;
    assign o_instr       = instr_reg;
    assign o_instr_pc    = instr_pc_reg;
    assign o_instr_valid = instr_valid_reg;

    // Fetch FSM: redirect beats ack/handshake; ack is only honoured in S_REQ
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= S_REQ;
            pc_reg          <= RESET_PC;
            addr_reg        <= RESET_PC;
            squash_reg      <= 1'b0;
            instr_reg       <= 32'h0;
            instr_pc_reg    <= 32'h0;
            instr_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (i_redirect) begin
                        pc_reg <= redirect_aligned;
                        if (i_imem_ack) begin
                            // Read completes this cycle: drop its data, start the new path next
                            addr_reg   <= redirect_aligned;
                            squash_reg <= 1'b0;
                        end else begin
                            // Read still pending: keep its address on the bus, kill its data later
                            squash_reg <= 1'b1;
                        end
                    end else if (i_imem_ack) begin
                        if (squash_reg) begin
                            squash_reg <= 1'b0;
                            addr_reg   <= pc_reg;
                        end else begin
                            instr_reg       <= i_imem_rdata;
                            instr_pc_reg    <= addr_reg;
                            instr_valid_reg <= 1'b1;
                            state_reg       <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (i_redirect) begin
                        // Instruction on offer is abandoned even if ready is high
                        pc_reg          <= redirect_aligned;
                        addr_reg        <= redirect_aligned;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= S_REQ;
                    end else if (i_instr_ready) begin
                        pc_reg          <= next_pc;
                        addr_reg        <= next_pc;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= S_REQ;
                    end
                end
                default: begin
                    state_reg <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A behavioural instruction memory is
// driven cycle by cycle; every non-squashed ack pushes the expected
// {instr, pc} onto a scoreboard that is popped when the DUT offers a word.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_e;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .OPC_J    (6'b000010),
        .OPC_JAL  (6'b000011)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2002_0005;
        if (a == 32'h0000_0100) return 32'h0800_0010;   // J  -> 0x40
        if (a == 32'h0000_0040) return 32'h0C00_0020;   // JAL -> 0x80
        return {16'h2002, a[15:0]};                     // addi, never a jump
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge the current request for one cycle; keep=1 means the data is expected downstream
    task automatic ack_cycle(input bit keep);
        exp_t e;
        imem_rdata = mem_word(imem_addr);
        imem_ack   = 1'b1;
        if (keep) begin
            e.instr = imem_rdata;
            e.pc    = imem_addr;
            sb_q.push_back(e);
        end
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got req=%b valid=%b instr=%h pc=%h, expected all 0",
                     imem_req, instr_valid, instr, instr_pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'(k * 4);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                failures++;
                $display("FAIL zero_wait_req[%0d]: got req=%b addr=%h, expected req=1 addr=%h",
                         k, imem_req, imem_addr, exp_addr);
            end
            ack_cycle(1'b1);
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL zero_wait_valid[%0d]: got valid=%b req=%b, expected valid=1 req=0",
                         k, instr_valid, imem_req);
            end
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL zero_wait_sb[%0d]: scoreboard empty", k);
            end else begin
                exp_e = sb_q.pop_front();
                if (instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                    failures++;
                    $display("FAIL zero_wait_data[%0d]: got instr=%h pc=%h, expected instr=%h pc=%h",
                             k, instr, instr_pc, exp_e.instr, exp_e.pc);
                end
            end
            $display("txn zero_wait pc=%h instr=%h", instr_pc, instr);
            tick();
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL zero_wait_drop[%0d]: got valid=%b, expected 0", k, instr_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        ack_cycle(1'b1);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL backpressure_sb: scoreboard empty");
        end else begin
            exp_e = sb_q[0];
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
                    instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                    failures++;
                    $display("FAIL backpressure_hold[%0d]: got valid=%b req=%b instr=%h pc=%h, expected valid=1 req=0 instr=%h pc=%h",
                             c, instr_valid, imem_req, instr, instr_pc, exp_e.instr, exp_e.pc);
                end
                // A stray ack while holding must be ignored
                if (c == 2) begin
                    imem_ack   = 1'b1;
                    imem_rdata = 32'hDEAD_BEEF;
                end
                tick();
                imem_ack   = 1'b0;
                imem_rdata = 32'h0;
            end
            exp_e = sb_q.pop_front();
            checks++;
            if (instr !== exp_e.instr || instr_pc !== exp_e.pc || instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_data: got valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                         instr_valid, instr, instr_pc, exp_e.instr, exp_e.pc);
            end
            $display("txn backpressure pc=%h instr=%h", instr_pc, instr);
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_next: got req=%b addr=%h valid=%b, expected req=1 addr=00000014 valid=0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_jump();
        // Redirect coinciding with ack: data dropped, new path starts next cycle
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        ack_cycle(1'b0);
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL redirect_with_ack: got valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00000100",
                     instr_valid, imem_req, imem_addr);
        end
        for (int j = 0; j < 2; j++) begin
            ack_cycle(1'b1);
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL jump_sb[%0d]: scoreboard empty", j);
            end else begin
                exp_e = sb_q.pop_front();
                if (instr_valid !== 1'b1 || instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                    failures++;
                    $display("FAIL jump_data[%0d]: got valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                             j, instr_valid, instr, instr_pc, exp_e.instr, exp_e.pc);
                end
            end
            $display("txn jump pc=%h instr=%h", instr_pc, instr);
            tick();
            checks++;
            if (imem_addr !== ((j == 0) ? 32'h40 : 32'h80) || imem_req !== 1'b1) begin
                failures++;
                $display("FAIL jump_target[%0d]: got req=%b addr=%h, expected req=1 addr=%h",
                         j, imem_req, imem_addr, (j == 0) ? 32'h40 : 32'h80);
            end
        end
    endtask

    task automatic test_redirect_wait();
        // Move the fetch to 0x8 first
        redirect = 1'b1; redirect_pc = 32'h0000_0008;
        ack_cycle(1'b0);
        redirect = 1'b0;
        // Redirect while the read for 0x8 is outstanding; ack arrives 3 cycles later
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL squash_hold[%0d]: got req=%b addr=%h valid=%b, expected req=1 addr=00000008 valid=0",
                         w, imem_req, imem_addr, instr_valid);
            end
            if (w < 2) tick();
        end
        ack_cycle(1'b0);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL squash_next: got valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00000200",
                     instr_valid, imem_req, imem_addr);
        end
        ack_cycle(1'b1);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL squash_sb: scoreboard empty");
        end else begin
            exp_e = sb_q.pop_front();
            if (instr_valid !== 1'b1 || instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                failures++;
                $display("FAIL squash_data: got valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                         instr_valid, instr, instr_pc, exp_e.instr, exp_e.pc);
            end
        end
        $display("txn redirect_wait pc=%h instr=%h", instr_pc, instr);
        tick();
    endtask

    task automatic test_redirect_in_out();
        instr_ready = 1'b0;
        ack_cycle(1'b1);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL out_redirect_sb: scoreboard empty");
        end else begin
            exp_e = sb_q.pop_front();   // offered but abandoned by the redirect
            if (instr_valid !== 1'b1 || instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                failures++;
                $display("FAIL out_redirect_offer: got valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                         instr_valid, instr, instr_pc, exp_e.instr, exp_e.pc);
            end
        end
        $display("txn redirect_in_out pc=%h instr=%h (abandoned)", instr_pc, instr);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0303;
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            failures++;
            $display("FAIL out_redirect_next: got valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00000300",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        ack_cycle(1'b0);
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_addr: got addr=%h, expected fffffffc", imem_addr);
        end
        ack_cycle(1'b1);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL wrap_sb: scoreboard empty");
        end else begin
            exp_e = sb_q.pop_front();
            if (instr_valid !== 1'b1 || instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                failures++;
                $display("FAIL wrap_data: got valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                         instr_valid, instr, instr_pc, exp_e.instr, exp_e.pc);
            end
        end
        $display("txn wrap pc=%h instr=%h", instr_pc, instr);
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: got req=%b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
        end
        // Reset while an instruction is on offer
        instr_ready = 1'b0;
        ack_cycle(1'b1);
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: got valid=%b, expected 1", instr_valid);
        end
        rst = 1'b1;
        tick();
        sb_q.delete();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b req=%b instr=%h pc=%h, expected all 0",
                     instr_valid, imem_req, instr, instr_pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_req: got req=%b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
        end
        instr_ready = 1'b1;
        ack_cycle(1'b1);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL post_reset_sb: scoreboard empty");
        end else begin
            exp_e = sb_q.pop_front();
            if (instr_valid !== 1'b1 || instr !== exp_e.instr || instr_pc !== exp_e.pc) begin
                failures++;
                $display("FAIL post_reset_data: got valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                         instr_valid, instr, instr_pc, exp_e.instr, exp_e.pc);
            end
        end
        $display("txn post_reset pc=%h instr=%h", instr_pc, instr);
        tick();
        checks++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_next: got req=%b addr=%h, expected req=1 addr=00000004", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_jump();
        test_redirect_wait();
        test_redirect_in_out();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
